// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: owns the PC, addresses instruction memory and registers each
// fetched word into a one-entry valid/ready output stage with redirect and fault.
module instr_fetch_seq #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              halt_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic              fault,
   output logic [31:0]       fault_pc,
   output logic [31:0]       fetch_count
);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic hs;
   logic redirect_bad;
   logic pc_oor;

   assign imem_addr    = pc_q[ADDR_W+1:2];
   assign hs           = out_valid_q && out_ready;
   assign redirect_bad = (|redirect_pc[1:0]) || (|redirect_pc[31:ADDR_W+2]);
   // PC only ever steps by 4 from an aligned value, so range is the only fetch-side check
   assign pc_oor       = |pc_q[31:ADDR_W+2];

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      fault_d       = fault_q;
      fault_pc_d    = fault_pc_q;
      fetch_count_d = fetch_count_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (hs) fetch_count_d = fetch_count_q + 32'd1;
            if (redirect_valid) begin
               out_valid_d = 1'b0;
               if (redirect_bad) begin
                  state_d    = FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (halt_req) begin
               if (hs) out_valid_d = 1'b0;
            end else if (!out_valid_q || out_ready) begin
               if (pc_oor) begin
                  state_d     = FAULT;
                  fault_d     = 1'b1;
                  fault_pc_d  = pc_q;
                  out_valid_d = 1'b0;
               end else begin
                  out_instr_d = imem_instr;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + 32'd4;
               end
            end
         end
         FAULT: begin
            out_valid_d = 1'b0;
            fault_d     = 1'b1;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         out_valid_q   <= 1'b0;
         out_instr_q   <= 32'd0;
         out_pc_q      <= 32'd0;
         fault_q       <= 1'b0;
         fault_pc_q    <= 32'd0;
         fetch_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
         fault_q       <= fault_d;
         fault_pc_q    <= fault_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign fault       = fault_q;
   assign fault_pc    = fault_pc_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: expected words are queued as stimulus is
// driven and compared against every completed output handshake.
module tb_instr_fetch_seq;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_instr;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              halt_req;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic              fault;
   logic [31:0]       fault_pc;
   logic [31:0]       fetch_count;

   logic [31:0] mem [64];
   logic [31:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr];

   instr_fetch_seq #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scores a handshake that will complete at the coming edge, then advances one cycle.
   task automatic cycle();
      logic [31:0] e;
      if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL hs_unexpected observed_pc=%h expected=none", out_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("hs_pc", out_pc, e);
            chk("hs_instr", out_instr, e >> 2);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_instr"}, out_instr, 32'd0);
      chk({tag, "_pc"}, out_pc, 32'd0);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
      chk({tag, "_fault_pc"}, fault_pc, 32'd0);
      chk({tag, "_count"}, fetch_count, 32'd0);
      chk({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = i;
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      halt_req = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      cycle();
      chk_reset_state("reset");

      // free run, then backpressure at out_pc=0x8
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      reset = 1'b0; out_ready = 1'b1;
      cycle();
      chk("boot_valid", {31'd0, out_valid}, 32'd0);
      cycle();
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      chk("first_pc", out_pc, 32'h0);
      cycle();
      chk("run_pc1", out_pc, 32'h4);
      chk("run_count1", fetch_count, 32'd1);
      cycle();
      chk("run_pc2", out_pc, 32'h8);
      chk("run_count2", fetch_count, 32'd2);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_pc", out_pc, 32'h8);
         chk("bp_instr", out_instr, 32'd2);
         chk("bp_addr", {26'd0, imem_addr}, 32'd3);
      end
      chk("bp_count", fetch_count, 32'd2);
      exp_q.push_back(32'hC); exp_q.push_back(32'h10);
      out_ready = 1'b1;
      cycle();
      chk("rel_pc", out_pc, 32'hC);
      chk("rel_instr", out_instr, 32'd3);
      cycle();
      cycle();
      chk("rel_count", fetch_count, 32'd5);
      chk("rel_pc2", out_pc, 32'h14);

      // redirect to 0x20 while a handshake completes at the same edge
      exp_q.push_back(32'h14);
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      cycle();
      chk("redir_bubble", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", {26'd0, imem_addr}, 32'd8);
      chk("redir_count", fetch_count, 32'd6);
      redirect_valid = 1'b0;
      exp_q.push_back(32'h20); exp_q.push_back(32'h24);
      cycle();
      chk("redir_valid", {31'd0, out_valid}, 32'd1);
      chk("redir_pc", out_pc, 32'h20);
      chk("redir_instr", out_instr, 32'd8);
      cycle();

      // halt: in-flight word drains, pc holds
      halt_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("halt_valid", {31'd0, out_valid}, 32'd0);
         chk("halt_addr", {26'd0, imem_addr}, 32'd10);
      end
      halt_req = 1'b0;
      exp_q.push_back(32'h28);
      cycle();
      chk("unhalt_pc", out_pc, 32'h28);
      chk("unhalt_count", fetch_count, 32'd8);

      // reset mid-stream beats a concurrent redirect
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      exp_q.delete();
      cycle();
      chk_reset_state("midreset");

      // overrun: 0xF8 and 0xFC delivered, then fault at 0x100
      reset = 1'b0; redirect_valid = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      cycle(); cycle();
      chk("restart_pc", out_pc, 32'h0);
      cycle();
      chk("restart_pc2", out_pc, 32'h4);
      redirect_valid = 1'b1; redirect_pc = 32'hF8;
      cycle();
      redirect_valid = 1'b0;
      exp_q.push_back(32'hF8); exp_q.push_back(32'hFC);
      cycle();
      chk("ovr_pc0", out_pc, 32'hF8);
      cycle();
      chk("ovr_pc1", out_pc, 32'hFC);
      chk("ovr_nofault", {31'd0, fault}, 32'd0);
      cycle();
      chk("ovr_fault", {31'd0, fault}, 32'd1);
      chk("ovr_fault_pc", fault_pc, 32'h100);
      chk("ovr_valid", {31'd0, out_valid}, 32'd0);
      chk("ovr_count", fetch_count, 32'd4);
      cycle();
      chk("ovr_stuck", {31'd0, out_valid}, 32'd0);

      // misaligned redirect, fault is sticky across later redirects
      reset = 1'b1;
      cycle();
      chk("clr_fault", {31'd0, fault}, 32'd0);
      reset = 1'b0; out_ready = 1'b0;
      cycle(); cycle();
      chk("mis_pre_valid", {31'd0, out_valid}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      cycle();
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_fault_pc", fault_pc, 32'h22);
      chk("mis_valid", {31'd0, out_valid}, 32'd0);
      redirect_pc = 32'h40; out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk("mis_stuck_valid", {31'd0, out_valid}, 32'd0);
         chk("mis_stuck_fault_pc", fault_pc, 32'h22);
      end
      redirect_valid = 1'b0; reset = 1'b1;
      cycle();
      chk_reset_state("final");
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Fetch sequencer for the single-cycle MIPS core. It owns the program counter, drives the word address of the 64-entry asynchronous-read `Instruction_Memory`, and registers each fetched word into a one-entry output stage with a valid/ready handshake to decode. It also applies branch/jump redirects and latches a sticky fault on misaligned or out-of-range fetch addresses.

## Interface
Parameters:
- `ADDR_W`, 6: instruction-memory word-index width; the memory holds 2^ADDR_W words.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned and in range.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `imem_addr` out ADDR_W: word index to instruction memory, combinational `pc[ADDR_W+1:2]`.
- `imem_instr` in 32: instruction word returned combinationally for `imem_addr`.
- `redirect_valid` in 1: load a new PC this cycle (branch or jump taken).
- `redirect_pc` in 32: byte address of the redirect target.
- `halt_req` in 1: while high, no new fetches; the output stage holds.
- `out_valid` out 1: `out_instr` and `out_pc` are valid.
- `out_ready` in 1: decode accepts the output word this cycle.
- `out_instr` out 32: fetched instruction.
- `out_pc` out 32: byte address of `out_instr`.
- `fault` out 1: sticky fault flag, cleared only by reset.
- `fault_pc` out 32: offending byte address.
- `fetch_count` out 32: number of completed output handshakes; wraps mod 2^32.

## Operation
- States: BOOT, RUN, FAULT.
- Reset: state BOOT, `pc` = RESET_PC. Outputs `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- BOOT: one cycle with no fetch, then RUN unconditionally.
- Handshake: completes when `out_valid && out_ready`. On completion, `fetch_count` increments.
- In RUN, the following rules are evaluated in priority order:
  1. `redirect_valid`:
     - Set `out_valid`<=0 (flush). A handshake completing in the same cycle still counts.
     - If `redirect_pc[1:0]`≠0 or `redirect_pc[31:ADDR_W+2]`≠0: go to FAULT, `fault`<=1, `fault_pc`<=`redirect_pc`.
     - Otherwise `pc`<=`redirect_pc`.
  2. `halt_req`: no fetch and `pc` holds. A completing handshake clears `out_valid`.
  3. Fetch is enabled when `!out_valid || out_ready`:
     - If `pc[31:ADDR_W+2]`≠0: go to FAULT, `fault_pc`<=`pc`, `out_valid`<=0.
     - Otherwise `out_instr`<=`imem_instr`, `out_pc`<=`pc`, `out_valid`<=1, `pc`<=`pc`+4.
  4. No fetch enabled: all registers hold.
- FAULT:
  - `out_valid`=0 and `fault`=1.
  - `redirect_valid`, `halt_req` and `out_ready` are ignored.
  - Only reset exits this state.
- PC arithmetic: 32-bit, modulo 2^32. Overrun is detected as out-of-range before any wrap can occur.

## Timing
- `imem_addr` follows `pc` combinationally. The memory read is zero-latency, and the output word is registered.
- After reset deasserts at edge E:
  - BOOT occupies cycle E→E+1.
  - The first word loads at edge E+2, so `out_valid`=1 from E+2.
- Steady state with `out_ready`=1: one instruction per cycle and `out_pc` advances by 4 each cycle.
- Backpressure (`out_ready`=0 with `out_valid`=1): `out_instr`, `out_pc` and `pc` hold exactly. No instruction is skipped or duplicated.
- Redirect sampled at edge N: `out_valid`=0 after N. The target word appears at edge N+1 (two-edge redirect latency).
- Reset asserted mid-operation overrides every other input at that edge.

## Test plan
- Free run: mem[i]=i, `out_ready`=1. After reset, `out_pc` = 0,4,8,… with `out_instr` = 0,1,2,… one per cycle starting at the second edge after reset; `fetch_count` increments every cycle.
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_pc`=0x8. Output holds 0x8/2; on release the next words are 0xC/3 then 0x10/4.
- Redirect: pulse `redirect_valid` with 0x20 while `out_pc`=0x4 and `out_ready`=1. One bubble follows, then `out_pc`=0x20 with `out_instr`=8; `fetch_count` includes the 0x4 handshake.
- Misaligned redirect to 0x22: `fault`=1, `fault_pc`=0x22, `out_valid` stuck at 0 despite further redirects; a reset then clears `fault`.
- Overrun: redirect to 0xF8. Words 0xF8 and 0xFC are delivered, then `fault`=1 with `fault_pc`=0x100.
- Halt and reset: `halt_req`=1 for 4 cycles holds `pc`. Reset asserted mid-stream returns all outputs to reset values and restarts at RESET_PC.
